// File: rtl/meikyuu_pkg.sv
// Shared definitions for the maze game: VGA timing, player spawn point,
// collision resolver state encoding and a small saturating-counter helper.
package meikyuu_pkg;

    localparam int VGA_H_TOTAL     = 800;
    localparam int VGA_V_TOTAL     = 525;
    localparam int VGA_H_ACT_START = 144;
    localparam int VGA_H_ACT_END   = 784;
    localparam int VGA_V_ACT_START = 35;
    localparam int VGA_V_ACT_END   = 515;

    localparam int PLAYER_X_SPAWN  = 439;
    localparam int PLAYER_Y_SPAWN  = 266;

    typedef enum logic [2:0] {
        WAIT_FRAME = 3'd0,
        ARM        = 3'd1,
        SCAN       = 3'd2,
        RESOLVE    = 3'd3
    } resolver_state_e;

    // Increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] satInc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/vga_region_decode.sv
// Decodes the beam counters into "inside the visible area" and
// "last pixel of the frame" flags. Purely combinational so the maze
// renderer can reuse it alongside the collision resolver.
module vga_region_decode
    import meikyuu_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int H_ACT_START = VGA_H_ACT_START,
    parameter int H_ACT_END   = VGA_H_ACT_END,
    parameter int V_ACT_START = VGA_V_ACT_START,
    parameter int V_ACT_END   = VGA_V_ACT_END
) (
    input  logic [9:0] h_counter_i,
    input  logic [9:0] v_counter_i,
    output logic       in_act_o,
    output logic       eof_o
);

    int hPos;
    int vPos;

    // Compare in integer space so the parameter bounds need no resizing.
    always_comb begin
        hPos     = int'(h_counter_i);
        vPos     = int'(v_counter_i);
        in_act_o = (hPos >= H_ACT_START) && (hPos < H_ACT_END) &&
                   (vPos >= V_ACT_START) && (vPos < V_ACT_END);
        eof_o    = (hPos == H_TOTAL - 1) && (vPos == V_TOTAL - 1);
    end

endmodule

// File: rtl/collision_resolver.sv
// Closes the player position loop once per frame. While the beam scans,
// overlaps between the sprite and wall/hazard pixels are tallied; at the
// first pixel of the next frame the proposed position is either committed
// or rejected, and the result is fed back to the player as x_pos/y_pos.
module collision_resolver
    import meikyuu_pkg::*;
#(
    parameter int H_TOTAL       = VGA_H_TOTAL,
    parameter int V_TOTAL       = VGA_V_TOTAL,
    parameter int H_ACT_START   = VGA_H_ACT_START,
    parameter int H_ACT_END     = VGA_H_ACT_END,
    parameter int V_ACT_START   = VGA_V_ACT_START,
    parameter int V_ACT_END     = VGA_V_ACT_END,
    parameter int X_SPAWN       = PLAYER_X_SPAWN,
    parameter int Y_SPAWN       = PLAYER_Y_SPAWN,
    parameter int HIT_THRESHOLD = 1
) (
    input  logic       CLOCK_25,
    input  logic       reset,
    input  logic [9:0] h_counter,
    input  logic [9:0] v_counter,
    input  logic [9:0] x_prop,
    input  logic [9:0] y_prop,
    input  logic       active_draw,
    input  logic       active_draw_back,
    input  logic       wall_pixel,
    input  logic       hazard_pixel,
    input  logic       room_change,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       collision,
    output logic       alive,
    output logic       frame_tick,
    output logic [7:0] wall_hits
);

    localparam logic [9:0] X_RESET = 10'(X_SPAWN);
    localparam logic [9:0] Y_RESET = 10'(Y_SPAWN);

    resolver_state_e state_q, state_d;
    logic [9:0] candX_q, candX_d;
    logic [9:0] candY_q, candY_d;
    logic [7:0] hits_q, hits_d;
    logic       hazard_q, hazard_d;
    logic       rcLatch_q, rcLatch_d;
    logic [9:0] xPos_q, xPos_d;
    logic [9:0] yPos_q, yPos_d;
    logic       collision_q, collision_d;
    logic       alive_q, alive_d;
    logic       frameTick_q, frameTick_d;
    logic [7:0] wallHits_q, wallHits_d;

    logic inAct;
    logic eof;
    logic spriteHit;
    logic rcPending;
    logic overThreshold;

    vga_region_decode #(
        .H_TOTAL     (H_TOTAL),
        .V_TOTAL     (V_TOTAL),
        .H_ACT_START (H_ACT_START),
        .H_ACT_END   (H_ACT_END),
        .V_ACT_START (V_ACT_START),
        .V_ACT_END   (V_ACT_END)
    ) u_region (
        .h_counter_i (h_counter),
        .v_counter_i (v_counter),
        .in_act_o    (inAct),
        .eof_o       (eof)
    );

    // Frame FSM: tally overlaps during SCAN, judge the frame in RESOLVE.
    always_comb begin
        state_d       = state_q;
        candX_d       = candX_q;
        candY_d       = candY_q;
        hits_d        = hits_q;
        hazard_d      = hazard_q;
        rcLatch_d     = rcLatch_q;
        xPos_d        = xPos_q;
        yPos_d        = yPos_q;
        collision_d   = collision_q;
        alive_d       = alive_q;
        frameTick_d   = 1'b0;
        wallHits_d    = wallHits_q;

        spriteHit     = inAct & (active_draw | active_draw_back);
        rcPending     = rcLatch_q | room_change;
        overThreshold = (int'(hits_q) >= HIT_THRESHOLD);

        case (state_q)
            WAIT_FRAME: begin
                if (eof) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                candX_d  = x_prop;
                candY_d  = y_prop;
                hits_d   = 8'd0;
                hazard_d = 1'b0;
                state_d  = SCAN;
            end
            SCAN: begin
                if (spriteHit && wall_pixel) begin
                    hits_d = satInc8(hits_q);
                end
                if (spriteHit && hazard_pixel) begin
                    hazard_d = 1'b1;
                end
                if (eof) begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                wallHits_d = hits_q;
                if (alive_q) begin
                    if (rcPending || !overThreshold) begin
                        xPos_d      = candX_q;
                        yPos_d      = candY_q;
                        collision_d = 1'b0;
                    end else begin
                        collision_d = 1'b1;
                    end
                    if (hazard_q && !rcPending) begin
                        alive_d = 1'b0;
                    end
                end
                rcLatch_d   = 1'b0;
                candX_d     = x_prop;
                candY_d     = y_prop;
                hits_d      = 8'd0;
                hazard_d    = 1'b0;
                frameTick_d = 1'b1;
                state_d     = SCAN;
            end
            default: begin
                state_d = WAIT_FRAME;
            end
        endcase

        // A room change seen outside RESOLVE is held until the next decision.
        if ((state_q != RESOLVE) && room_change) begin
            rcLatch_d = 1'b1;
        end
    end

    // State and output registers; reset puts the player back at spawn.
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            state_q     <= WAIT_FRAME;
            candX_q     <= X_RESET;
            candY_q     <= Y_RESET;
            hits_q      <= 8'd0;
            hazard_q    <= 1'b0;
            rcLatch_q   <= 1'b0;
            xPos_q      <= X_RESET;
            yPos_q      <= Y_RESET;
            collision_q <= 1'b0;
            alive_q     <= 1'b1;
            frameTick_q <= 1'b0;
            wallHits_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            candX_q     <= candX_d;
            candY_q     <= candY_d;
            hits_q      <= hits_d;
            hazard_q    <= hazard_d;
            rcLatch_q   <= rcLatch_d;
            xPos_q      <= xPos_d;
            yPos_q      <= yPos_d;
            collision_q <= collision_d;
            alive_q     <= alive_d;
            frameTick_q <= frameTick_d;
            wallHits_q  <= wallHits_d;
        end
    end

    assign x_pos      = xPos_q;
    assign y_pos      = yPos_q;
    assign collision  = collision_q;
    assign alive      = alive_q;
    assign frame_tick = frameTick_q;
    assign wall_hits  = wallHits_q;

endmodule

// File: tb/tb_collision_resolver.sv
// Bench for collision_resolver on a shrunken VGA raster (40x24) so that
// dozens of frames fit in a short run. Directed frames come from a table of
// expected results; randomized frames are judged by a frame-level model.
module tb_collision_resolver;

    localparam int H_T = 40;
    localparam int V_T = 24;
    localparam int HAS = 8;
    localparam int HAE = 36;
    localparam int VAS = 2;
    localparam int VAE = 22;
    localparam int XS  = 439;
    localparam int YS  = 266;
    localparam int TH  = 1;
    localparam int NVEC = 12;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] hCounter, vCounter, xProp, yProp;
    logic       activeDraw, activeDrawBack, wallPixel, hazardPixel, roomChange;
    logic [9:0] xPos, yPos;
    logic       collision, alive, frameTick;
    logic [7:0] wallHits;

    int vectors = 0;
    int miscompares = 0;

    // Frame-level model of the resolver
    int mX, mY, mHits, frameHits, candX, candY;
    bit mCol, mAlive, frameHaz, armed, primed, rcLatch, lastDecision;

    typedef struct {
        int xp;
        int yp;
        int nWall;
        bit blank;
        bit haz;
        int rc;
        int expX;
        int expY;
        bit expCol;
        int expHits;
        bit expAlive;
    } vec_t;

    vec_t tbl[NVEC];

    always #5 clock = ~clock;

    collision_resolver #(
        .H_TOTAL       (H_T),
        .V_TOTAL       (V_T),
        .H_ACT_START   (HAS),
        .H_ACT_END     (HAE),
        .V_ACT_START   (VAS),
        .V_ACT_END     (VAE),
        .X_SPAWN       (XS),
        .Y_SPAWN       (YS),
        .HIT_THRESHOLD (TH)
    ) dut (
        .CLOCK_25         (clock),
        .reset            (reset),
        .h_counter        (hCounter),
        .v_counter        (vCounter),
        .x_prop           (xProp),
        .y_prop           (yProp),
        .active_draw      (activeDraw),
        .active_draw_back (activeDrawBack),
        .wall_pixel       (wallPixel),
        .hazard_pixel     (hazardPixel),
        .room_change      (roomChange),
        .x_pos            (xPos),
        .y_pos            (yPos),
        .collision        (collision),
        .alive            (alive),
        .frame_tick       (frameTick),
        .wall_hits        (wallHits)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic setVec(input int i, input int xp, input int yp, input int nWall,
                          input bit blank, input bit haz, input int rc,
                          input int expX, input int expY, input bit expCol,
                          input int expHits, input bit expAlive);
        tbl[i].xp = xp;       tbl[i].yp = yp;       tbl[i].nWall = nWall;
        tbl[i].blank = blank; tbl[i].haz = haz;     tbl[i].rc = rc;
        tbl[i].expX = expX;   tbl[i].expY = expY;   tbl[i].expCol = expCol;
        tbl[i].expHits = expHits; tbl[i].expAlive = expAlive;
    endtask

    task automatic applyStimulus(input int h, input int v, input bit ad, input bit adb,
                                 input bit wl, input bit hz, input bit rc,
                                 input int xp, input int yp, input bit rs);
        hCounter       = 10'(h);
        vCounter       = 10'(v);
        activeDraw     = ad;
        activeDrawBack = adb;
        wallPixel      = wl;
        hazardPixel    = hz;
        roomChange     = rc;
        xProp          = 10'(xp);
        yProp          = 10'(yp);
        reset          = rs;
        @(posedge clock);
        #1;
    endtask

    task automatic modelReset();
        mX = XS; mY = YS; mCol = 0; mAlive = 1; mHits = 0;
        armed = 0; primed = 0; rcLatch = 0;
        frameHits = 0; frameHaz = 0; candX = XS; candY = YS;
    endtask

    task automatic checkModel(input string tag, input bit expTick);
        checkOutput({tag, "_x"}, int'(xPos), mX);
        checkOutput({tag, "_y"}, int'(yPos), mY);
        checkOutput({tag, "_col"}, int'(collision), int'(mCol));
        checkOutput({tag, "_alive"}, int'(alive), int'(mAlive));
        checkOutput({tag, "_hits"}, int'(wallHits), mHits);
        checkOutput({tag, "_tick"}, int'(frameTick), int'(expTick));
    endtask

    task automatic checkVec(input int k);
        string tag;
        tag = $sformatf("vec%0d", k);
        checkOutput({tag, "_x"}, int'(xPos), tbl[k].expX);
        checkOutput({tag, "_y"}, int'(yPos), tbl[k].expY);
        checkOutput({tag, "_col"}, int'(collision), int'(tbl[k].expCol));
        checkOutput({tag, "_alive"}, int'(alive), int'(tbl[k].expAlive));
        checkOutput({tag, "_hits"}, int'(wallHits), tbl[k].expHits);
        checkOutput({tag, "_tick"}, int'(frameTick), 1);
    endtask

    task automatic doReset();
        modelReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5, 5, 0, 0, 0, 0, 0, XS, YS, 1);
        end
    endtask

    // Beam position (0,0): the cycle in which a judged frame is decided.
    task automatic startSweep(input int xp, input int yp, input bit rcStart);
        bit pending;
        lastDecision = armed;
        if (armed) begin
            pending = rcLatch || rcStart;
            rcLatch = 0;
            if (mAlive) begin
                if (pending || frameHits < TH) begin
                    mX = candX; mY = candY; mCol = 0;
                end else begin
                    mCol = 1;
                end
                if (frameHaz && !pending) mAlive = 0;
            end
            mHits = (frameHits > 255) ? 255 : frameHits;
        end else if (rcStart) begin
            rcLatch = 1;
        end
        armed = primed;
        if (armed) begin
            candX = xp; candY = yp; frameHits = 0; frameHaz = 0;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, rcStart, xp, yp, 0);
    endtask

    // Rest of the raster after (0,0); pixel content is directed or random.
    task automatic bodySweep(input int nWall, input bit blank, input bit haz,
                             input bit rcMid, input bit rnd, input int resetV,
                             input int xpIn, input int ypIn);
        int actIdx;
        int wallPct;
        int ticks;
        actIdx = 0;
        ticks = 0;
        case ($urandom_range(0, 3))
            0: wallPct = 0;
            1: wallPct = 1;
            2: wallPct = 10;
            default: wallPct = 70;
        endcase
        for (int v = 0; v < V_T; v++) begin
            for (int h = 0; h < H_T; h++) begin
                bit ia, ad, adb, wl, hz, rc, rs;
                int xp, yp;
                if (h == 0 && v == 0) continue;
                ia = (h >= HAS) && (h < HAE) && (v >= VAS) && (v < VAE);
                ad = 0; adb = 0; wl = 0; hz = 0; rc = 0;
                xp = xpIn; yp = ypIn;
                if (rnd) begin
                    ad  = ($urandom_range(0, 3) != 0);
                    adb = ($urandom_range(0, 7) == 0);
                    wl  = ($urandom_range(0, 99) < wallPct);
                    hz  = ($urandom_range(0, 19999) == 0);
                    rc  = ($urandom_range(0, 2999) == 0);
                    xp  = $urandom_range(400, 520);
                    yp  = $urandom_range(200, 300);
                end else begin
                    if (ia && actIdx < nWall) begin
                        if (actIdx % 2 == 1) ad = 1; else adb = 1;
                        wl = 1;
                    end
                    if (blank && ((h == 2 && v == VAS + 1) || (h == 20 && v == 0))) begin
                        ad = 1; wl = 1;
                    end
                    if (haz && h == 20 && v == 10) begin
                        adb = 1; hz = 1;
                    end
                    if (rcMid && h == 5 && v == 12) rc = 1;
                end
                if (ia) actIdx++;
                rs = (v == resetV) && (h == 0);
                if (rs) begin
                    rc = 0;
                    modelReset();
                end else begin
                    if (ia && (ad || adb) && wl) frameHits++;
                    if (ia && (ad || adb) && hz) frameHaz = 1;
                    if (rc) rcLatch = 1;
                    if (h == H_T - 1 && v == V_T - 1) primed = 1;
                end
                applyStimulus(h, v, ad, adb, wl, hz, rc, xp, yp, rs);
                if (rs) checkModel("midreset", 0);
                if (frameTick) ticks++;
            end
        end
        checkOutput("stray_tick", ticks, 0);
    endtask

    initial begin
        bit rcs;
        reset = 1; hCounter = 0; vCounter = 0; xProp = 0; yProp = 0;
        activeDraw = 0; activeDrawBack = 0; wallPixel = 0; hazardPixel = 0; roomChange = 0;

        //      idx  xp   yp  nWall blank haz rc   expX expY col hits alive
        setVec(0,  450, 266,   0, 0, 0, 0,  450, 266, 0,   0, 1);
        setVec(1,  450, 266,   0, 0, 0, 0,  450, 266, 0,   0, 1);
        setVec(2,  460, 266,   3, 0, 0, 0,  450, 266, 1,   3, 1);
        setVec(3,  460, 266,   0, 0, 0, 0,  460, 266, 0,   0, 1);
        setVec(4,  470, 270, 300, 0, 0, 0,  460, 266, 1, 255, 1);
        setVec(5,  470, 270,   0, 1, 0, 0,  470, 270, 0,   0, 1);
        setVec(6,  480, 270,   5, 0, 0, 1,  480, 270, 0,   5, 1);
        setVec(7,  490, 271,   5, 0, 0, 2,  490, 271, 0,   5, 1);
        setVec(8,  495, 271,   2, 0, 0, 0,  490, 271, 1,   2, 1);
        setVec(9,  490, 271,   1, 0, 1, 0,  490, 271, 1,   1, 0);
        setVec(10, 510, 280,   0, 0, 0, 0,  490, 271, 1,   0, 0);
        setVec(11, 512, 280,   4, 0, 0, 1,  490, 271, 1,   4, 0);

        $display("[TB] directed table");
        doReset();
        startSweep(450, 266, 0);
        checkOutput("reset_x", int'(xPos), XS);
        checkOutput("reset_y", int'(yPos), YS);
        checkOutput("reset_col", int'(collision), 0);
        checkOutput("reset_alive", int'(alive), 1);
        checkOutput("reset_hits", int'(wallHits), 0);
        checkOutput("reset_tick", int'(frameTick), 0);
        bodySweep(0, 0, 0, 0, 0, -1, 450, 266);
        for (int i = 0; i < NVEC; i++) begin
            rcs = (i > 0) ? (tbl[i-1].rc == 2) : 1'b0;
            startSweep(tbl[i].xp, tbl[i].yp, rcs);
            if (i > 0) checkVec(i - 1);
            bodySweep(tbl[i].nWall, tbl[i].blank, tbl[i].haz, tbl[i].rc == 1, 0, -1,
                      tbl[i].xp, tbl[i].yp);
        end
        startSweep(XS, YS, tbl[NVEC-1].rc == 2);
        checkVec(NVEC - 1);

        $display("[TB] reset in mid-frame");
        doReset();
        startSweep(455, 266, 0);
        bodySweep(0, 0, 0, 0, 0, -1, 455, 266);
        startSweep(455, 266, 0);
        checkModel("rst_arm", 0);
        bodySweep(0, 0, 0, 0, 0, -1, 455, 266);
        startSweep(460, 266, 0);
        checkModel("rst_pre", 1);
        bodySweep(0, 0, 0, 0, 0, 12, 460, 266);
        startSweep(465, 266, 0);
        checkModel("rst_partial", 0);
        bodySweep(0, 0, 0, 0, 0, -1, 465, 266);
        startSweep(470, 266, 0);
        checkModel("rst_full", 1);
        checkOutput("rst_full_xval", int'(xPos), 465);

        $display("[TB] randomized frames");
        for (int b = 0; b < 3; b++) begin
            doReset();
            startSweep($urandom_range(400, 520), $urandom_range(200, 300), 0);
            checkModel("rnd_warm", lastDecision);
            bodySweep(0, 0, 0, 0, 1, -1, 0, 0);
            for (int s = 0; s < 6; s++) begin
                startSweep($urandom_range(400, 520), $urandom_range(200, 300),
                           $urandom_range(0, 9) == 0);
                checkModel("rnd", lastDecision);
                bodySweep(0, 0, 0, 0, 1, -1, 0, 0);
            end
            startSweep($urandom_range(400, 520), $urandom_range(200, 300), 0);
            checkModel("rnd_last", lastDecision);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/collision_resolver.md
# collision_resolver

Closes the position loop of the maze game. Each frame it watches the player sprite's per-pixel draw signals against the maze renderer's wall and hazard pixels while the VGA beam scans. At end of frame it either commits the player's proposed position or reverts to the last safe one, and drives that committed position back into the player's position inputs. It also owns the player's `enable` (alive) signal.

## Interface
Parameters:
- `H_TOTAL`, 800: pixel clocks per line.
- `V_TOTAL`, 525: lines per frame.
- `H_ACT_START`, 144: first active column.
- `H_ACT_END`, 784: first column after the active area.
- `V_ACT_START`, 35: first active line.
- `V_ACT_END`, 515: first line after the active area.
- `X_SPAWN`, 439: reset x position.
- `Y_SPAWN`, 266: reset y position.
- `HIT_THRESHOLD`, 1: number of overlapping wall pixels per frame that counts as a collision.

Ports:
- `CLOCK_25` in 1: pixel clock. One clock; everything is on it.
- `reset` in 1: synchronous, active-high.
- `h_counter` in 10: beam column.
- `v_counter` in 10: beam line.
- `x_prop` in 10: proposed x, from the player `x_pos_out`.
- `y_prop` in 10: proposed y, from the player `y_pos_out`.
- `active_draw` in 1: sprite body pixel at the beam.
- `active_draw_back` in 1: sprite detail pixel at the beam.
- `wall_pixel` in 1: maze wall at the beam.
- `hazard_pixel` in 1: lethal tile at the beam.
- `room_change` in 1: 1-cycle pulse when the map room index changes.
- `x_pos` out 10: committed x, to the player `x_pos_in`.
- `y_pos` out 10: committed y, to the player `y_pos_in`.
- `collision` out 1: last frame overlapped a wall.
- `alive` out 1: to the player `enable`. 0 means dead.
- `frame_tick` out 1: 1-cycle pulse on each decision.
- `wall_hits` out 8: saturating overlap count from the last judged frame (debug).

## Operation
- Sprite pixel `sp` = `active_draw | active_draw_back`.
- `in_act` = `H_ACT_START <= h_counter < H_ACT_END` and `V_ACT_START <= v_counter < V_ACT_END`.
- `eof` = (`h_counter == H_TOTAL-1`) and (`v_counter == V_TOTAL-1`).
- States:
  - WAIT_FRAME: on `eof` go to ARM.
  - ARM (1 cycle): sample `x_prop`/`y_prop` into the candidate registers, clear the per-frame hit counter and hazard flag, go to SCAN. No decision is made.
  - SCAN: each cycle with `in_act & sp & wall_pixel`, increment the 8-bit hit counter (saturates at 255). Each cycle with `in_act & sp & hazard_pixel`, set the hazard flag. On `eof` go to RESOLVE.
  - RESOLVE (1 cycle): make the decision below, then sample a new candidate, clear the counters, pulse `frame_tick`, go to SCAN.
- Decision at RESOLVE:
  - If room-change is pending: commit the candidate and clear `collision`, regardless of the hit count.
  - Else if hits >= `HIT_THRESHOLD`: keep the committed position and set `collision`.
  - Else: commit the candidate and clear `collision`.
  - In all three cases, `wall_hits` takes the final count.
  - If the hazard flag is set and room-change is not pending, `alive` goes to 0.
- Room-change pending = sticky latch set by a `room_change` pulse, OR `room_change` asserted in the RESOLVE cycle itself. The latch clears at RESOLVE.
- `alive` = 0 is permanent until `reset`.
- When `alive` = 0, positions freeze: no further commits, `collision` holds.
- Pixels outside `in_act` are ignored, even if `sp` is high.

## Timing
- Reset values: `x_pos` = `X_SPAWN`, `y_pos` = `Y_SPAWN`, `collision` = 0, `alive` = 1, `frame_tick` = 0, `wall_hits` = 0. State = WAIT_FRAME; room-change latch clear.
- Reset asserted mid-frame: the next decision comes only after one full ARM-to-RESOLVE frame. A partial frame is never judged.
- RESOLVE and ARM fall on the cycle after `eof`, i.e. beam (0,0), which is blanking, so no active pixel is missed.
- All outputs are registered. `x_pos`/`y_pos`/`collision`/`wall_hits`/`alive` change only on the clock edge that ends RESOLVE, and are stable for a full frame.
- Latency: from the last scanned pixel to the updated outputs is 2 cycles.
- The candidate is sampled once per frame, so mid-frame changes on `x_prop`/`y_prop` do not affect the frame being judged.

## Structure
- `meikyuu_pkg` holds the VGA timing constants, `X_SPAWN`/`Y_SPAWN` and the state encoding (3-bit localparams: WAIT_FRAME, ARM, SCAN, RESOLVE). The player and maze renderer share these.
- One combinational sub-module, `vga_region_decode`, produces `in_act` and `eof` from the counters. It is reusable by the renderer.
- Everything else lives in a single sequential module.

## Test plan
- After reset, run 2 clean frames with `sp`=0 and `x_prop`=450 → after the 2nd RESOLVE: `x_pos`=450, `collision`=0, `wall_hits`=0, one `frame_tick` per frame.
- 3 overlapping wall pixels in the active area, candidate (460,266) → committed position stays (450,266), `collision`=1, `wall_hits`=3. The next clean frame commits 460 and clears `collision`.
- 300 overlap pixels → `wall_hits`=255 (saturated), `collision`=1.
- Wall overlap with `room_change` pulsed mid-frame → candidate is committed, `collision`=0. Repeat with the pulse exactly in the RESOLVE cycle → same result.
- One hazard overlap at (200,100) → `alive`=0 after RESOLVE. A later clean frame with a new `x_prop` → `x_pos` unchanged, `alive` stays 0 until `reset`.
- `sp`&`wall_pixel` only at h=100 (blanking) → no hit. Reset asserted at v=300 → no `frame_tick` until after the first full frame.
